// File: rtl/proc_trace_checker.sv
// rtl/proc_trace_checker.sv - in-order commit trace checker against a preloaded expected-record table
module proc_trace_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_addr,
  input  logic [31:0]              load_data,
  input  logic                     load_dchk,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     start,
  input  logic                     trace_val,
  input  logic [31:0]              trace_addr,
  input  logic [31:0]              trace_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [31:0]              fail_addr,
  output logic [31:0]              fail_data,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   checked
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_tab_addr [DEPTH];
  logic [31:0]     r_tab_data [DEPTH];
  logic            r_tab_dchk [DEPTH];
  logic [CW-1:0]   r_num;
  logic [CW-1:0]   r_checked;
  logic [TW-1:0]   r_idle;
  logic [IW-1:0]   r_fail_idx;
  logic [31:0]     r_fail_addr;
  logic [31:0]     r_fail_data;
  logic            r_timeout;

  logic [IW-1:0]   w_idx;
  logic            w_match;
  logic            w_num_ok;
  logic            w_last;
  logic            w_idle_hit;

  assign w_idx      = r_checked[IW-1:0];
  assign w_match    = (trace_addr == r_tab_addr[w_idx]) &&
                      (!r_tab_dchk[w_idx] || (trace_data == r_tab_data[w_idx]));
  assign w_num_ok   = (num_entries != '0) && (num_entries <= CW'(DEPTH));
  assign w_last     = (r_checked + CW'(1)) == r_num;
  assign w_idle_hit = (r_idle + TW'(1)) == TW'(TIMEOUT);

  // Expected-record table; survives reset so a rerun needs no reload
  always_ff @(posedge clk) begin
    if (!rst && load_en && r_state == S_IDLE) begin
      r_tab_addr[load_idx] <= load_addr;
      r_tab_data[load_idx] <= load_data;
      r_tab_dchk[load_idx] <= load_dchk;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_num_ok ? S_RUN : S_FAIL;
      S_RUN: begin
        if (trace_val)       w_next = !w_match ? S_FAIL : (w_last ? S_PASS : S_RUN);
        else if (w_idle_hit) w_next = S_FAIL;
      end
      S_PASS:  if (start) w_next = S_IDLE;
      S_FAIL:  if (start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Progress counter, idle counter and failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= '0;
      r_checked   <= '0;
      r_idle      <= '0;
      r_fail_idx  <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_checked   <= '0;
            r_idle      <= '0;
            r_fail_idx  <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_timeout   <= 1'b0;
            if (w_num_ok) r_num <= num_entries;
          end
        end
        S_RUN: begin
          if (trace_val) begin
            r_idle <= '0;
            if (w_match) begin
              r_checked <= r_checked + CW'(1);
            end else begin
              r_fail_idx  <= w_idx;
              r_fail_addr <= trace_addr;
              r_fail_data <= trace_data;
            end
          end else if (w_idle_hit) begin
            r_timeout   <= 1'b1;
            r_fail_idx  <= w_idx;
            r_fail_addr <= '0;
            r_fail_data <= '0;
          end else begin
            r_idle <= r_idle + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status decode from the registered state and capture registers
  always_comb begin
    busy      = (r_state == S_RUN);
    done      = (r_state == S_PASS) || (r_state == S_FAIL);
    pass      = (r_state == S_PASS);
    fail      = (r_state == S_FAIL);
    fail_idx  = r_fail_idx;
    fail_addr = r_fail_addr;
    fail_data = r_fail_data;
    timeout   = r_timeout;
    checked   = r_checked;
  end

endmodule

// File: tb/tb_proc_trace_checker.sv
// tb/tb_proc_trace_checker.sv - self-checking bench for proc_trace_checker
module tb_proc_trace_checker;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4;
  localparam int IW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [31:0]   load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          load_dchk = 1'b0;
  logic [IW:0]   num_entries = '0;
  logic          start = 1'b0;
  logic          trace_val = 1'b0;
  logic [31:0]   trace_addr = '0;
  logic [31:0]   trace_data = '0;
  logic          busy, done, pass, fail, timeout;
  logic [IW-1:0] fail_idx;
  logic [31:0]   fail_addr, fail_data;
  logic [IW:0]   checked;

  int checks = 0;
  int errors = 0;

  proc_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_data(load_data), .load_dchk(load_dchk),
    .num_entries(num_entries), .start(start), .trace_val(trace_val),
    .trace_addr(trace_addr), .trace_data(trace_data), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .fail_idx(fail_idx), .fail_addr(fail_addr),
    .fail_data(fail_data), .timeout(timeout), .checked(checked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ek;
    logic [31:0] ta;
    logic [31:0] td;
    logic        exp_pass;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d, input logic k);
    load_en = 1'b1; load_idx = IW'(idx); load_addr = a; load_data = d; load_dchk = k;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_entries = (IW+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic trace(input logic [31:0] a, input logic [31:0] d);
    trace_val = 1'b1; trace_addr = a; trace_data = d;
    tick();
    trace_val = 1'b0;
  endtask

  task automatic to_idle(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_done"}, done, 0);
  endtask

  task automatic load_std();
    load(0, 32'h200, 32'h2, 1'b1);
    load(1, 32'h204, 32'h3, 1'b1);
    load(2, 32'h208, 32'h0, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] ea [DEPTH];
    logic [31:0] ed [DEPTH];
    logic        ek [DEPTH];
    logic [31:0] ta [DEPTH];
    logic [31:0] td [DEPTH];
    int          gap [DEPTH];

    vecs[0] = '{32'h100, 32'hAA, 1'b1, 32'h100, 32'hAA, 1'b1};
    vecs[1] = '{32'h100, 32'hAA, 1'b1, 32'h100, 32'hAB, 1'b0};
    vecs[2] = '{32'h100, 32'hAA, 1'b0, 32'h100, 32'h55, 1'b1};
    vecs[3] = '{32'h100, 32'hAA, 1'b0, 32'h104, 32'hAA, 1'b0};
    vecs[4] = '{32'hFFFFFFFC, 32'h0, 1'b1, 32'hFFFFFFFC, 32'h0, 1'b1};
    vecs[5] = '{32'h0, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h7FFFFFFF, 1'b0};

    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);     chk("rst_fail", fail, 0);
    chk("rst_timeout", timeout, 0); chk("rst_fail_idx", fail_idx, 0);
    chk("rst_fail_addr", fail_addr, 0); chk("rst_fail_data", fail_data, 0);
    chk("rst_checked", checked, 0);

    // full pass on consecutive commits
    load_std();
    do_start(3);
    chk("p_busy", busy, 1); chk("p_checked0", checked, 0);
    trace(32'h200, 32'h2);
    trace(32'h204, 32'h3);
    chk("p_pass_early", pass, 0); chk("p_checked2", checked, 2);
    trace(32'h208, 32'hDEAD);
    chk("p_pass", pass, 1); chk("p_fail", fail, 0); chk("p_done", done, 1);
    chk("p_checked", checked, 3); chk("p_busy_end", busy, 0);
    trace(32'h999, 32'h1);
    chk("p_sticky", pass, 1); chk("p_checked_sat", checked, 3);
    to_idle("p");

    // data mismatch on record 1
    do_start(3);
    trace(32'h200, 32'h2);
    trace(32'h204, 32'h4);
    chk("d_fail", fail, 1); chk("d_idx", fail_idx, 1);
    chk("d_addr", fail_addr, 32'h204); chk("d_data", fail_data, 32'h4);
    chk("d_timeout", timeout, 0); chk("d_checked", checked, 1);
    trace(32'h208, 32'h5);
    chk("d_sticky_addr", fail_addr, 32'h204); chk("d_sticky_fail", fail, 1);
    to_idle("d");

    // branch fell through: expected 0x20C, committed 0x210
    load(3, 32'h20C, 32'h0, 1'b0);
    do_start(4);
    trace(32'h200, 32'h2); trace(32'h204, 32'h3); trace(32'h208, 32'h7);
    trace(32'h210, 32'h0);
    chk("b_fail", fail, 1); chk("b_idx", fail_idx, 3); chk("b_addr", fail_addr, 32'h210);
    to_idle("b");

    // timeout exactly TIMEOUT idle cycles after a match
    do_start(2);
    trace(32'h200, 32'h2);
    repeat (TIMEOUT - 1) tick();
    chk("t_not_yet", fail, 0); chk("t_busy", busy, 1);
    tick();
    chk("t_fail", fail, 1); chk("t_timeout", timeout, 1); chk("t_idx", fail_idx, 1);
    chk("t_addr", fail_addr, 0); chk("t_data", fail_data, 0);
    to_idle("t");

    // commit on the threshold cycle wins over the timeout
    do_start(2);
    trace(32'h200, 32'h2);
    repeat (TIMEOUT - 1) tick();
    trace(32'h204, 32'h3);
    chk("tw_pass", pass, 1); chk("tw_timeout", timeout, 0);
    to_idle("tw");

    // reset mid-run, then rerun the preserved table
    do_start(3);
    trace(32'h200, 32'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("r_busy", busy, 0); chk("r_done", done, 0); chk("r_checked", checked, 0);
    chk("r_fail", fail, 0); chk("r_pass", pass, 0);
    do_start(3);
    trace(32'h200, 32'h2); trace(32'h204, 32'h3); trace(32'h208, 32'h0);
    chk("r_rerun_pass", pass, 1);
    to_idle("r");

    // num_entries out of range
    do_start(0);
    chk("n0_fail", fail, 1); chk("n0_idx", fail_idx, 0); chk("n0_timeout", timeout, 0);
    to_idle("n0");
    chk("n0_fail_cleared", fail, 0);
    do_start(DEPTH + 1);
    chk("nbig_fail", fail, 1); chk("nbig_busy", busy, 0);
    to_idle("nbig");

    // load during RUN is ignored
    do_start(3);
    load(1, 32'hBAD, 32'hBAD, 1'b1);
    trace(32'h200, 32'h2); trace(32'h204, 32'h3); trace(32'h208, 32'h1);
    chk("lr_pass", pass, 1);
    to_idle("lr");

    // load and start together: new slot visible to first compare
    load_en = 1'b1; load_idx = '0; load_addr = 32'h300; load_data = 32'h0; load_dchk = 1'b0;
    num_entries = 1; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    trace(32'h300, 32'h1234);
    chk("ls_pass", pass, 1);
    to_idle("ls");

    // single-record compare vectors
    for (int v = 0; v < 6; v++) begin
      load(0, vecs[v].ea, vecs[v].ed, vecs[v].ek);
      do_start(1);
      trace(vecs[v].ta, vecs[v].td);
      chk($sformatf("vec%0d_pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("vec%0d_fail", v), fail, !vecs[v].exp_pass);
      to_idle($sformatf("vec%0d", v));
    end

    // randomized runs against a transaction-level outcome model
    for (int s = 0; s < 40; s++) begin
      int n, nm, last;
      logic e_pass, e_to;
      logic [31:0] e_idx, e_fa, e_fd;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        int kind;
        ea[i] = $urandom & 32'hFFFF_FFFC;
        ed[i] = $urandom;
        ek[i] = 1'($urandom_range(0, 1));
        load(i, ea[i], ed[i], ek[i]);
        gap[i] = ($urandom_range(0, 11) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
        kind = $urandom_range(0, 9);
        ta[i] = (kind == 0) ? (ea[i] ^ 32'h4) : ea[i];
        td[i] = (kind == 1) ? (ed[i] ^ 32'h1) : (ek[i] ? ed[i] : $urandom);
      end
      e_pass = 1'b1; e_to = 1'b0; e_idx = 0; e_fa = 0; e_fd = 0; nm = 0; last = n - 1;
      for (int i = 0; i < n; i++) begin
        if (gap[i] >= TIMEOUT) begin
          e_pass = 1'b0; e_to = 1'b1; e_idx = i; last = i; break;
        end
        if (ta[i] != ea[i] || (ek[i] && td[i] != ed[i])) begin
          e_pass = 1'b0; e_idx = i; e_fa = ta[i]; e_fd = td[i]; last = i; break;
        end
        nm++;
      end
      do_start(n);
      for (int i = 0; i <= last; i++) begin
        repeat (gap[i]) tick();
        if (gap[i] >= TIMEOUT) break;
        trace(ta[i], td[i]);
        if (i < last) chk($sformatf("rnd%0d_mid_checked", s), checked, i + 1);
      end
      repeat ($urandom_range(0, 2)) trace($urandom, $urandom);
      chk($sformatf("rnd%0d_pass", s), pass, e_pass);
      chk($sformatf("rnd%0d_fail", s), fail, !e_pass);
      chk($sformatf("rnd%0d_timeout", s), timeout, e_to);
      chk($sformatf("rnd%0d_checked", s), checked, nm);
      if (!e_pass) begin
        chk($sformatf("rnd%0d_idx", s), fail_idx, e_idx);
        chk($sformatf("rnd%0d_faddr", s), fail_addr, e_fa);
        chk($sformatf("rnd%0d_fdata", s), fail_data, e_fd);
      end
      to_idle($sformatf("rnd%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
